// File: rtl/pr_rp_bridge.sv
// Static-side bridge for the reconfigurable button/LED partition: conditions board
// buttons into the RP, returns RP LEDs to the pins, and isolates both during reconfiguration.
module pr_rp_bridge #(
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned SETTLE_CYCLES   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn0_raw,
  input  logic btn1_raw,
  input  logic pr_decouple,
  output logic rp_btn0,
  output logic rp_btn1,
  input  logic rp_led0,
  input  logic rp_led1,
  output logic led0,
  output logic led1,
  output logic rp_active,
  output logic btn0_evt,
  output logic btn1_evt
);

  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_ISOLATED = 2'd0,
    ST_SETTLE   = 2'd1,
    ST_ACTIVE   = 2'd2
  } state_t;

  logic [1:0]       btn_raw_s;
  logic [1:0]       sync1_r;
  logic [1:0]       sync2_r;
  logic [1:0]       db_r;
  logic [1:0]       db_q_r;
  logic [1:0]       evt_r;
  logic [CNT_W-1:0] db_cnt_r [2];
  logic [1:0]       rp_led_q_r;
  state_t           state_r;
  logic [CNT_W-1:0] settle_cnt_r;
  logic             led0_r;
  logic             led1_r;
  logic             active_r;
  logic             gate_s;

  assign btn_raw_s = {btn1_raw, btn0_raw};

  // Button synchronisers, per-button debouncers and rising-edge event pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 2'b00;
      sync2_r <= 2'b00;
      db_r    <= 2'b00;
      db_q_r  <= 2'b00;
      evt_r   <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        db_cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      sync1_r <= btn_raw_s;
      sync2_r <= sync1_r;
      db_q_r  <= db_r;
      evt_r   <= db_r & ~db_q_r;
      // Any sample matching the accepted state restarts the stability count.
      for (int i = 0; i < 2; i++) begin
        if (sync2_r[i] == db_r[i]) begin
          db_cnt_r[i] <= CNT_ZERO;
        end else if (db_cnt_r[i] == DB_LAST) begin
          db_r[i]     <= ~db_r[i];
          db_cnt_r[i] <= CNT_ZERO;
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + CNT_ONE;
        end
      end
    end
  end

  // Isolation FSM; LED and active outputs are registered from the next-state decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      rp_led_q_r   <= 2'b00;
      state_r      <= ST_ISOLATED;
      settle_cnt_r <= CNT_ZERO;
      led0_r       <= 1'b0;
      led1_r       <= 1'b0;
      active_r     <= 1'b0;
    end else begin
      rp_led_q_r <= {rp_led1, rp_led0};
      case (state_r)
        ST_ISOLATED: begin
          led0_r   <= 1'b0;
          led1_r   <= 1'b0;
          active_r <= 1'b0;
          if (!pr_decouple) begin
            state_r      <= ST_SETTLE;
            settle_cnt_r <= CNT_ZERO;
          end else begin
            state_r <= ST_ISOLATED;
          end
        end
        ST_SETTLE: begin
          if (pr_decouple) begin
            state_r  <= ST_ISOLATED;
            led0_r   <= 1'b0;
            led1_r   <= 1'b0;
            active_r <= 1'b0;
          end else if (settle_cnt_r == SETTLE_LAST) begin
            state_r  <= ST_ACTIVE;
            led0_r   <= rp_led_q_r[0];
            led1_r   <= rp_led_q_r[1];
            active_r <= 1'b1;
          end else begin
            settle_cnt_r <= settle_cnt_r + CNT_ONE;
            led0_r       <= 1'b0;
            led1_r       <= 1'b0;
            active_r     <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          // Dropping the pins on the same edge keeps stale RP values off the board.
          if (pr_decouple) begin
            state_r  <= ST_ISOLATED;
            led0_r   <= 1'b0;
            led1_r   <= 1'b0;
            active_r <= 1'b0;
          end else begin
            state_r  <= ST_ACTIVE;
            led0_r   <= rp_led_q_r[0];
            led1_r   <= rp_led_q_r[1];
            active_r <= 1'b1;
          end
        end
        default: begin
          state_r  <= ST_ISOLATED;
          led0_r   <= 1'b0;
          led1_r   <= 1'b0;
          active_r <= 1'b0;
        end
      endcase
    end
  end

  // Combinational gate so the RP sees 0 in the very cycle decouple rises.
  assign gate_s    = ~pr_decouple & (state_r != ST_ISOLATED);
  assign rp_btn0   = db_r[0] & gate_s;
  assign rp_btn1   = db_r[1] & gate_s;
  assign led0      = led0_r;
  assign led1      = led1_r;
  assign rp_active = active_r;
  assign btn0_evt  = evt_r[0];
  assign btn1_evt  = evt_r[1];

endmodule

// File: tb/tb_pr_rp_bridge.sv
// Self-checking bench for pr_rp_bridge: direct output checks plus an event scoreboard
// holding the cycle at which each button event is due.
module tb_pr_rp_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn0_raw = 1'b0;
  logic btn1_raw = 1'b0;
  logic pr_decouple = 1'b0;
  logic rp_led0 = 1'b0;
  logic rp_led1 = 1'b0;
  logic rp_btn0, rp_btn1, led0, led1, rp_active, btn0_evt, btn1_evt;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int q0[$];
  int q1[$];

  pr_rp_bridge #(
    .CNT_W(16),
    .DEBOUNCE_CYCLES(8),
    .SETTLE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn0_raw(btn0_raw),
    .btn1_raw(btn1_raw),
    .pr_decouple(pr_decouple),
    .rp_btn0(rp_btn0),
    .rp_btn1(rp_btn1),
    .rp_led0(rp_led0),
    .rp_led1(rp_led1),
    .led0(led0),
    .led1(led1),
    .rp_active(rp_active),
    .btn0_evt(btn0_evt),
    .btn1_evt(btn1_evt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Event scoreboard: every pulse must match the next due cycle in its queue.
  always @(negedge clk) begin
    if (btn0_evt === 1'b1) begin
      if (q0.size() == 0) check("evt0_extra", 1, 0);
      else check("evt0_cycle", cyc, q0.pop_front());
    end
    if (btn1_evt === 1'b1) begin
      if (q1.size() == 0) check("evt1_extra", 1, 0);
      else check("evt1_cycle", cyc, q1.pop_front());
    end
  end

  function automatic int outs();
    return int'({rp_btn0, rp_btn1, led0, led1, rp_active, btn0_evt, btn1_evt});
  endfunction

  initial begin
    int n;
    int a;
    int r;

    // 1: reset for 3 cycles, then ISOLATED -> SETTLE x4 -> ACTIVE
    repeat (3) begin
      @(negedge clk);
      check("t1_reset_outs", outs(), 0);
    end
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("t1_active", int'(rp_active), (k == 5) ? 1 : 0);
      check("t1_leds", int'({led0, led1}), 0);
    end

    // 2: clean btn0 press while ACTIVE
    n = cyc;
    btn0_raw = 1'b1;
    q0.push_back(n + 11);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check("t2_rp_btn0", int'(rp_btn0), (k >= 10) ? 1 : 0);
      check("t2_rp_btn1", int'(rp_btn1), 0);
    end

    // 3: btn1 bounce: high 5, low 1, high 20
    n = cyc;
    btn1_raw = 1'b1;
    q1.push_back(n + 17);
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      check("t3_rp_btn1", int'(rp_btn1), (k >= 16) ? 1 : 0);
      if (k == 5) btn1_raw = 1'b0;
      if (k == 6) btn1_raw = 1'b1;
    end

    // 4: LED passthrough latency, then decouple
    rp_led0 = 1'b1;
    rp_led1 = 1'b0;
    @(negedge clk);
    check("t4_led0_early", int'(led0), 0);
    @(negedge clk);
    check("t4_led0", int'(led0), 1);
    check("t4_led1", int'(led1), 0);
    check("t4_active", int'(rp_active), 1);
    pr_decouple = 1'b1;
    #1;
    check("t4_rp_btn_gated", int'({rp_btn0, rp_btn1}), 0);
    check("t4_led0_hold", int'(led0), 1);
    @(negedge clk);
    check("t4_led0_off", int'(led0), 0);
    check("t4_active_off", int'(rp_active), 0);
    check("t4_rp_btn_iso", int'({rp_btn0, rp_btn1}), 0);

    // 5: decouple low 2, high 1, then low: settle window restarts
    a = cyc;
    pr_decouple = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("t5_active", int'(rp_active), (k == 8) ? 1 : 0);
      check("t5_rp_btn0", int'(rp_btn0), (k == 3) ? 0 : 1);
      if (k == 2) pr_decouple = 1'b1;
      if (k == 3) pr_decouple = 1'b0;
    end
    check("t5_cycle", cyc, a + 8);

    // 6: one-cycle reset with both buttons held
    @(negedge clk);
    r = cyc;
    rst = 1'b1;
    @(negedge clk);
    check("t6_reset_outs", outs(), 0);
    rst = 1'b0;
    q0.push_back(r + 12);
    q1.push_back(r + 12);
    for (int k = 2; k <= 13; k++) begin
      @(negedge clk);
      check("t6_rp_btn0", int'(rp_btn0), (cyc >= r + 11) ? 1 : 0);
      check("t6_rp_btn1", int'(rp_btn1), (cyc >= r + 11) ? 1 : 0);
      check("t6_active", int'(rp_active), (cyc >= r + 6) ? 1 : 0);
    end

    repeat (3) @(negedge clk);
    check("evt0_pending", q0.size(), 0);
    check("evt1_pending", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/pr_rp_bridge.md
Name: pr_rp_bridge

Overview:
- Static-region counterpart of the reconfigurable button/LED partition.
- Conditions the two raw board buttons (synchronise, debounce, edge-detect) and drives them into the reconfigurable partition (RP).
- Samples the RP's two LED outputs back to the board pins.
- Isolates both directions while the reconfiguration controller asserts decouple, and waits a settle window after release before trusting RP outputs.

Parameters:
CNT_W, 16, width of debounce and settle counters
DEBOUNCE_CYCLES, 50000, consecutive stable cycles needed to accept a button change (1..2^CNT_W-1)
SETTLE_CYCLES, 16, cycles after decouple release before RP outputs are passed to the pins (1..2^CNT_W-1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
btn0_raw  in  1  raw button 0 from pad, asynchronous
btn1_raw  in  1  raw button 1 from pad, asynchronous
pr_decouple  in  1  high while the RP is being reconfigured, synchronous to clk
rp_btn0  out  1  conditioned button 0 to RP
rp_btn1  out  1  conditioned button 1 to RP
rp_led0  in  1  LED 0 from RP
rp_led1  in  1  LED 1 from RP
led0  out  1  board LED 0
led1  out  1  board LED 1
rp_active  out  1  high while RP outputs are passed through (state ACTIVE)
btn0_evt  out  1  one-cycle pulse on debounced rising edge of button 0
btn1_evt  out  1  one-cycle pulse on debounced rising edge of button 1

Behaviour:
- Reset (rst=1 at posedge):
  - all outputs 0
  - FSM=ISOLATED
  - synchroniser flops, debounced states and all counters 0
- Synchroniser: 2-flop chain per raw button. The RP LED inputs are same-clock but registered once (rp_led*_q) before use.
- Debouncer, per button, independent:
  - If synced value == debounced state: counter cleared to 0.
  - Otherwise: counter increments.
  - When counter == DEBOUNCE_CYCLES-1 and the value still differs: debounced state flips and counter clears on that edge.
  - Any single-cycle return to the debounced value restarts the count.
  - Latency from a clean raw edge to the debounced change is 2+DEBOUNCE_CYCLES cycles.
- btnN_evt: high for exactly one cycle, the cycle after the debounced state goes 0->1. There is no event on 1->0. Events are generated in every FSM state.
- rp_btnN = debounced_N AND NOT pr_decouple AND (FSM != ISOLATED). This is combinational gating, so the RP sees 0 in the same cycle decouple rises.
- FSM:
  - ISOLATED
    - led0=led1=0, rp_active=0.
    - pr_decouple=0 -> SETTLE, with settle counter cleared.
  - SETTLE
    - rp_btn driven, LEDs still 0, rp_active=0.
    - Counter increments each cycle.
    - pr_decouple=1 -> ISOLATED, taking priority.
    - Counter == SETTLE_CYCLES-1 -> ACTIVE.
    - Exactly SETTLE_CYCLES cycles are spent in SETTLE.
  - ACTIVE
    - rp_active=1.
    - ledN registered from rp_ledN_q, giving 2 cycles from rp_ledN to ledN.
    - pr_decouple=1 -> ISOLATED.
- Output registers: led0/led1/rp_active are registered from the next-state value. In the edge where decouple is first sampled high in ACTIVE, ledN and rp_active go 0 on that same edge; no stale RP value reaches the pins afterwards.
- Decouple pulse of one cycle in SETTLE or ACTIVE: forces a full ISOLATED->SETTLE cycle, with the settle window restarted from 0.
- rst asserted mid-debounce or mid-settle: discards all progress. Debounced states return to 0 and no event is emitted.
- Simultaneous button changes: fully independent. Both events may pulse in the same cycle.
- Arithmetic: all counters unsigned CNT_W bits. They never wrap, because they are bounded by the parameter compares.

Test Plan:
(Test parameters for all scenarios: DEBOUNCE_CYCLES=8, SETTLE_CYCLES=4.)
1. Reset release with pr_decouple=0:
   - rst high 3 cycles, then low -> ISOLATED 1 cycle, SETTLE 4 cycles, then rp_active=1.
   - All outputs 0 throughout reset.
2. btn0_raw 0->1 held steady, FSM ACTIVE:
   - rp_btn0 rises 10 cycles after the raw edge.
   - btn0_evt is a single pulse 1 cycle later.
   - btn1 outputs stay 0.
3. Bounce on btn1_raw (high 5 cycles, low 1, high 20):
   - The debounced change occurs 8 stable cycles after the final rise, plus the 2-cycle synchroniser.
   - Exactly one btn1_evt.
4. FSM ACTIVE, rp_led0=1, rp_led1=0:
   - led0=1, led1=0 two cycles later.
   - Raise pr_decouple: rp_btn0/1=0 the same cycle; led0=0 and rp_active=0 after the next edge.
5. pr_decouple low 2 cycles then high 1 cycle then low:
   - Never reaches ACTIVE early.
   - The SETTLE count restarts, and ACTIVE follows 4 full SETTLE cycles after the final release.
6. Both buttons debounced high, then rst pulsed 1 cycle:
   - rp_btn0/1, debounced states and events all 0 after reset.
   - Buttons still held -> re-accepted 10 cycles after rst falls.
